// File: rtl/unidade_controle.sv
// Control unit for a simple multi-cycle processor: 4-state FSM decoding a 9-bit
// instruction {opcode, Rx, Ry} into register/bus enables for mv, mvi, add and sub.
module unidade_controle (
  input  logic       p_Clock,
  input  logic       p_Resetn,
  input  logic       p_Run,
  input  logic [8:0] p_IR,
  output logic       p_IRWriteOn,
  output logic [7:0] p_RegWriteOn,
  output logic [7:0] p_RegOut,
  output logic       p_DINOut,
  output logic       p_AWriteOn,
  output logic       p_GWriteOn,
  output logic       p_GOut,
  output logic       p_AddSub,
  output logic       p_Done,
  output logic [1:0] p_State
);

  typedef enum logic [1:0] {
    StT0 = 2'b00,
    StT1 = 2'b01,
    StT2 = 2'b10,
    StT3 = 2'b11
  } state_e;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvi = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;

  state_e     state_q, state_d;
  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [7:0] rx_sel;
  logic [7:0] ry_sel;

  assign opcode = p_IR[8:6];
  assign rx     = p_IR[5:3];
  assign ry     = p_IR[2:0];
  assign rx_sel = 8'b0000_0001 << rx;
  assign ry_sel = 8'b0000_0001 << ry;

  always_ff @(posedge p_Clock or negedge p_Resetn) begin
    if (!p_Resetn) begin
      state_q <= StT0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    p_IRWriteOn  = 1'b0;
    p_RegWriteOn = 8'h00;
    p_RegOut     = 8'h00;
    p_DINOut     = 1'b0;
    p_AWriteOn   = 1'b0;
    p_GWriteOn   = 1'b0;
    p_GOut       = 1'b0;
    p_AddSub     = 1'b0;
    p_Done       = 1'b0;

    // Outputs are gated by reset so a held reset never asserts an enable,
    // even while p_Run is high in T0.
    if (p_Resetn) begin
      unique case (state_q)
        StT0: begin
          if (p_Run) begin
            p_IRWriteOn = 1'b1;
            state_d     = StT1;
          end
        end
        StT1: begin
          case (opcode)
            OpMv: begin
              p_RegOut     = ry_sel;
              p_RegWriteOn = rx_sel;
              p_Done       = 1'b1;
              state_d      = StT0;
            end
            OpMvi: begin
              p_DINOut     = 1'b1;
              p_RegWriteOn = rx_sel;
              p_Done       = 1'b1;
              state_d      = StT0;
            end
            OpAdd, OpSub: begin
              p_RegOut   = rx_sel;
              p_AWriteOn = 1'b1;
              state_d    = StT2;
            end
            default: begin
              // Undefined opcodes retire as a no-op.
              p_Done  = 1'b1;
              state_d = StT0;
            end
          endcase
        end
        StT2: begin
          p_RegOut   = ry_sel;
          p_GWriteOn = 1'b1;
          p_AddSub   = opcode[0];
          state_d    = StT3;
        end
        StT3: begin
          p_GOut       = 1'b1;
          p_RegWriteOn = rx_sel;
          p_Done       = 1'b1;
          state_d      = StT0;
        end
      endcase
    end
  end

  assign p_State = state_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed vector table, reset/back-to-back
// sequences and randomized traffic against an instruction-level reference model.
module tb_unidade_controle;

  logic       p_Clock;
  logic       p_Resetn;
  logic       p_Run;
  logic [8:0] p_IR;
  logic       p_IRWriteOn;
  logic [7:0] p_RegWriteOn;
  logic [7:0] p_RegOut;
  logic       p_DINOut;
  logic       p_AWriteOn;
  logic       p_GWriteOn;
  logic       p_GOut;
  logic       p_AddSub;
  logic       p_Done;
  logic [1:0] p_State;

  unidade_controle dut (
    .p_Clock     (p_Clock),
    .p_Resetn    (p_Resetn),
    .p_Run       (p_Run),
    .p_IR        (p_IR),
    .p_IRWriteOn (p_IRWriteOn),
    .p_RegWriteOn(p_RegWriteOn),
    .p_RegOut    (p_RegOut),
    .p_DINOut    (p_DINOut),
    .p_AWriteOn  (p_AWriteOn),
    .p_GWriteOn  (p_GWriteOn),
    .p_GOut      (p_GOut),
    .p_AddSub    (p_AddSub),
    .p_Done      (p_Done),
    .p_State     (p_State)
  );

  initial p_Clock = 1'b0;
  always #5 p_Clock = ~p_Clock;

  // {irw, regw[7:0], regout[7:0], din, a, g, gout, addsub, done, state[1:0]}
  logic [24:0] act;
  assign act = {p_IRWriteOn, p_RegWriteOn, p_RegOut, p_DINOut, p_AWriteOn, p_GWriteOn,
                p_GOut, p_AddSub, p_Done, p_State};

  int total = 0;
  int bad   = 0;
  int phase = 0;  // cycle index within the current instruction, 0 = fetch/idle
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] r);
    total++;
    if (a !== r) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, r, $time);
    end
  endtask

  function automatic logic [24:0] mk(logic irw, logic [7:0] rw, logic [7:0] ro, logic din,
                                     logic a, logic g, logic gout, logic as, logic done,
                                     logic [1:0] st);
    return {irw, rw, ro, din, a, g, gout, as, done, st};
  endfunction

  // Reference: what an instruction does in its k-th cycle.
  function automatic logic [24:0] model_out(int ph, logic run, logic [8:0] ir, logic rstn);
    logic irw, din, a, g, gout, as, done;
    logic [7:0] rw, ro;
    int op, rx, ry;
    irw = 0; din = 0; a = 0; g = 0; gout = 0; as = 0; done = 0; rw = 0; ro = 0;
    op = int'(ir[8:6]); rx = int'(ir[5:3]); ry = int'(ir[2:0]);
    if (!rstn) return '0;
    case (ph)
      0: irw = run;
      1: begin
        if (op == 0) begin ro[ry] = 1; rw[rx] = 1; done = 1; end
        else if (op == 1) begin din = 1; rw[rx] = 1; done = 1; end
        else if (op == 2 || op == 3) begin ro[rx] = 1; a = 1; end
        else done = 1;
      end
      2: begin ro[ry] = 1; g = 1; as = ir[6]; end
      default: begin gout = 1; rw[rx] = 1; done = 1; end
    endcase
    return mk(irw, rw, ro, din, a, g, gout, as, done, 2'(ph));
  endfunction

  function automatic int next_phase(int ph, logic run, logic [8:0] ir, logic rstn);
    int len;
    if (!rstn) return 0;
    len = (ir[8:7] == 2'b01) ? 4 : 2;
    if (ph == 0) return run ? 1 : 0;
    return (ph + 1 == len) ? 0 : ph + 1;
  endfunction

  // One cycle: drive, check just after settling, advance model at the rising edge.
  task automatic tick(input logic run, input logic [8:0] ir, input logic rstn,
                      input logic use_tbl, input logic [24:0] tbl_exp);
    p_Run = run; p_IR = ir; p_Resetn = rstn;
    #1;
    chk("model", 32'(act), 32'(model_out(phase, run, ir, rstn)));
    if (use_tbl) chk("table", 32'(act), 32'(tbl_exp));
    @(posedge p_Clock);
    phase = next_phase(phase, run, ir, rstn);
    @(negedge p_Clock);
  endtask

  // Single bus driver and at most one register write in every cycle.
  always @(negedge p_Clock) begin
    #2;
    if (mon_en) begin
      chk("bus_excl", 32'($countones({p_RegOut, p_DINOut, p_GOut}) <= 1), 32'd1);
      chk("wr_onehot0", 32'($onehot0(p_RegWriteOn)), 32'd1);
    end
  end

  typedef struct {
    logic        run;
    logic [8:0]  ir;
    logic [24:0] exp;
  } vec_t;

  localparam logic [8:0] MV    = 9'b000_010_101;
  localparam logic [8:0] MVI   = 9'b001_111_000;
  localparam logic [8:0] SUB   = 9'b011_001_110;
  localparam logic [8:0] MV33  = 9'b000_011_011;
  localparam logic [8:0] ADD11 = 9'b010_001_001;
  localparam logic [8:0] ADD00 = 9'b010_000_000;
  localparam logic [8:0] UND   = 9'b110_000_000;

  initial begin
    vec_t vecs[$];
    logic [8:0] cur_ir;
    logic       rstn_r;
    logic [24:0] z;
    z = '0;

    for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 9'd0, z});
    vecs.push_back('{1'b1, MV,    mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)});
    vecs.push_back('{1'b0, MV,    mk(0, 8'h04, 8'h20, 0, 0, 0, 0, 0, 1, 2'd1)});
    vecs.push_back('{1'b1, MVI,   mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)});
    vecs.push_back('{1'b0, MVI,   mk(0, 8'h80, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1)});
    vecs.push_back('{1'b1, SUB,   mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)});
    vecs.push_back('{1'b0, SUB,   mk(0, 8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 2'd1)});
    vecs.push_back('{1'b1, SUB,   mk(0, 8'h00, 8'h40, 0, 0, 1, 0, 1, 0, 2'd2)});
    vecs.push_back('{1'b0, SUB,   mk(0, 8'h02, 8'h00, 0, 0, 0, 1, 0, 1, 2'd3)});
    vecs.push_back('{1'b0, SUB,   z});
    vecs.push_back('{1'b1, MV33,  mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)});
    vecs.push_back('{1'b0, MV33,  mk(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1, 2'd1)});
    vecs.push_back('{1'b1, ADD11, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0)});
    vecs.push_back('{1'b0, ADD11, mk(0, 8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 2'd1)});
    vecs.push_back('{1'b0, ADD11, mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 2'd2)});
    vecs.push_back('{1'b0, ADD11, mk(0, 8'h02, 8'h00, 0, 0, 0, 1, 0, 1, 2'd3)});
    vecs.push_back('{1'b0, ADD11, z});

    p_Resetn = 1'b0; p_Run = 1'b0; p_IR = '0;
    mon_en = 1'b1;
    tick(1'b0, 9'd0, 1'b0, 1'b1, z);
    tick(1'b1, MV, 1'b0, 1'b1, z);  // run ignored while in reset

    foreach (vecs[i]) tick(vecs[i].run, vecs[i].ir, 1'b1, 1'b1, vecs[i].exp);

    // add R0,R0 aborted by reset during T2.
    tick(1'b1, ADD00, 1'b1, 1'b1, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
    tick(1'b0, ADD00, 1'b1, 1'b1, mk(0, 8'h00, 8'h01, 0, 1, 0, 0, 0, 0, 2'd1));
    #1;
    chk("pre_rst_state", 32'(p_State), 32'd2);
    p_Resetn = 1'b0;
    #1;
    chk("async_rst", 32'(act), 32'd0);
    @(posedge p_Clock);
    @(negedge p_Clock);
    phase = 0;
    tick(1'b1, ADD00, 1'b0, 1'b1, z);
    tick(1'b0, ADD00, 1'b1, 1'b1, z);
    tick(1'b0, ADD00, 1'b1, 1'b1, z);

    // Back-to-back with run held high: undefined then mv.
    tick(1'b1, UND, 1'b1, 1'b1, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
    tick(1'b1, UND, 1'b1, 1'b1, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1));
    tick(1'b1, MV,  1'b1, 1'b1, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0));
    tick(1'b1, MV,  1'b1, 1'b1, mk(0, 8'h04, 8'h20, 0, 0, 0, 0, 0, 1, 2'd1));
    tick(1'b0, MV,  1'b1, 1'b1, z);

    // Randomized traffic; IR only changes between instructions.
    cur_ir = MV;
    for (int n = 0; n < 500; n++) begin
      if (phase == 0 && $urandom_range(0, 1) == 1) begin
        cur_ir = 9'($urandom);
        if ($urandom_range(0, 3) != 0) cur_ir[8] = 1'b0;
      end
      rstn_r = ($urandom_range(0, 39) != 0);
      tick(1'($urandom_range(0, 2) != 0), cur_ir, rstn_r, 1'b0, z);
    end

    mon_en = 1'b0;
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
